// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU issue path.
//  - SEW_* : element-width codes carried on instr_sew / out_sew
//  - epb() : elements per datapath beat for a given element width
//  - valu_state_e : issue FSM states
package valu_pkg;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } valu_state_e;

  // Elements carried by one beat: byte lanes divided by bytes per element.
  function automatic int unsigned epb(input logic [1:0] sew, input int unsigned byte_en_width);
    return byte_en_width >> sew;
  endfunction

endpackage

// File: rtl/valu_tail_be.sv
// Tail byte-enable generator.
//  i_rem_elems : elements still to be processed from this beat onward
//  i_sew       : element width code
//  o_be        : byte enables; the low (i_rem_elems << i_sew) lanes, saturating
//                to all ones when the remainder covers the whole beat
module valu_tail_be #(
  parameter int VL_WIDTH  = 11,
  parameter int SEW_WIDTH = 2,
  parameter int BE_WIDTH  = 8
) (
  input  logic [VL_WIDTH:0]    i_rem_elems,
  input  logic [SEW_WIDTH-1:0] i_sew,
  output logic [BE_WIDTH-1:0]  o_be
);

  // Wide enough for the remainder scaled by the largest element size (8 bytes).
  localparam int NB_W = VL_WIDTH + 5;

  logic [NB_W-1:0] w_nbytes;

  assign w_nbytes = NB_W'(i_rem_elems) << i_sew;

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    o_be = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      o_be[i] = (NB_W'(i) < w_nbytes);
    end
  end

endmodule

// File: rtl/valu_req_issuer.sv
// Issue side of the vector add/min/max pipeline.
// Accepts one instruction (instr_*), walks its beats reading both source
// lines from the register file (rf_rd_*), and presents one registered beat
// per cycle to the ALU (out_*). No backpressure.
//  clk, rst           : clock, synchronous active-high reset
//  instr_*            : instruction handshake and fields
//  rf_rd_en/addr0/1   : register-file read request (combinational from state)
//  rf_rd_data0/1      : read data, one cycle after rf_rd_en
//  out_*              : ALU request beat, all zero when out_valid is low
module valu_req_issuer
  import valu_pkg::*;
#(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int SEW_WIDTH         = 2,
  parameter int OPSEL_WIDTH       = 9,
  parameter int VL_WIDTH          = 11,
  parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vs1,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vs2,
  input  logic [REQ_ADDR_WIDTH-1:0]    instr_vd,
  input  logic [VL_WIDTH-1:0]          instr_vl,
  input  logic [SEW_WIDTH-1:0]         instr_sew,
  input  logic [OPSEL_WIDTH-1:0]       instr_opSel,
  input  logic                         instr_avg,
  output logic                         rf_rd_en,
  output logic [REQ_ADDR_WIDTH-1:0]    rf_rd_addr0,
  output logic [REQ_ADDR_WIDTH-1:0]    rf_rd_addr1,
  input  logic [REQ_DATA_WIDTH-1:0]    rf_rd_data0,
  input  logic [REQ_DATA_WIDTH-1:0]    rf_rd_data1,
  output logic                         out_valid,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
  output logic [SEW_WIDTH-1:0]         out_sew,
  output logic [OPSEL_WIDTH-1:0]       out_opSel,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [5:0]                   out_start_idx,
  output logic                         out_req_start,
  output logic                         out_req_end,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic                         out_avg,
  output logic                         out_mask
);

  localparam int OFF_W   = VL_WIDTH + 1;  // element offsets never wrap
  localparam int LOG2_DW = $clog2(REQ_DATA_WIDTH);

  // Latched instruction and FSM.
  valu_state_e                r_state;
  logic [VL_WIDTH-1:0]        r_beat;
  logic [REQ_ADDR_WIDTH-1:0]  r_vs1, r_vs2, r_vd;
  logic [VL_WIDTH-1:0]        r_vl;
  logic [SEW_WIDTH-1:0]       r_sew;
  logic [OPSEL_WIDTH-1:0]     r_opsel;
  logic                       r_avg;

  // Sideband for the beat whose read is in flight (aligned with rf data).
  logic                         r_s1_valid, r_s1_start, r_s1_end, r_s1_avg;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_s1_be;
  logic [5:0]                   r_s1_idx;
  logic [REQ_ADDR_WIDTH-1:0]    r_s1_addr;
  logic [SEW_WIDTH-1:0]         r_s1_sew;
  logic [OPSEL_WIDTH-1:0]       r_s1_opsel;

  // Registered ALU beat.
  logic                         r_out_valid, r_out_start, r_out_end, r_out_avg, r_out_mask;
  logic [REQ_DATA_WIDTH-1:0]    r_out_vec0, r_out_vec1;
  logic [SEW_WIDTH-1:0]         r_out_sew;
  logic [OPSEL_WIDTH-1:0]       r_out_opsel;
  logic [REQ_ADDR_WIDTH-1:0]    r_out_addr;
  logic [5:0]                   r_out_idx;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_out_be;

  logic                         w_issue, w_last, w_mask, w_launch;
  logic [OFF_W-1:0]             w_epb, w_elem_off, w_rem;
  logic [REQ_ADDR_WIDTH-1:0]    w_dst;
  logic [REQ_BYTE_EN_WIDTH-1:0] w_be;

  assign w_issue    = (r_state == ST_ISSUE);
  assign w_epb      = OFF_W'(epb(r_sew, REQ_BYTE_EN_WIDTH));
  assign w_elem_off = {1'b0, r_beat} * w_epb;
  assign w_rem      = {1'b0, r_vl} - w_elem_off;
  assign w_last     = (w_rem <= w_epb);
  assign w_mask     = r_opsel[OPSEL_WIDTH-1];

  // Mask results pack one bit per element, so a destination line holds
  // REQ_DATA_WIDTH elements rather than one beat's worth.
  assign w_dst = w_mask ? r_vd + REQ_ADDR_WIDTH'(w_elem_off >> LOG2_DW)
                        : r_vd + REQ_ADDR_WIDTH'(r_beat);

  // Zero-length instructions and element widths wider than the datapath
  // are accepted but produce no beats.
  assign w_launch = (instr_vl != '0) &&
                    !((REQ_DATA_WIDTH < 64) && (instr_sew == SEW_WIDTH'(SEW_64)));

  valu_tail_be #(
    .VL_WIDTH  (VL_WIDTH),
    .SEW_WIDTH (SEW_WIDTH),
    .BE_WIDTH  (REQ_BYTE_EN_WIDTH)
  ) u_tail_be (
    .i_rem_elems (w_rem),
    .i_sew       (r_sew),
    .o_be        (w_be)
  );

  assign instr_ready = (r_state == ST_IDLE);
  assign rf_rd_en    = w_issue;
  assign rf_rd_addr0 = w_issue ? r_vs1 + REQ_ADDR_WIDTH'(r_beat) : '0;
  assign rf_rd_addr1 = w_issue ? r_vs2 + REQ_ADDR_WIDTH'(r_beat) : '0;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, because every output must read zero out of reset.
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vd    <= '0;
      r_vl    <= '0;
      r_sew   <= '0;
      r_opsel <= '0;
      r_avg   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_vs1   <= instr_vs1;
            r_vs2   <= instr_vs2;
            r_vd    <= instr_vd;
            r_vl    <= instr_vl;
            r_sew   <= instr_sew;
            r_opsel <= instr_opSel;
            r_avg   <= instr_avg;
            r_beat  <= '0;
            if (w_launch) r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + VL_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sideband travels one stage so it meets the read data it belongs to;
  // clearing r_s1_valid on reset discards any read already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_end   <= 1'b0;
      r_s1_avg   <= 1'b0;
      r_s1_be    <= '0;
      r_s1_idx   <= '0;
      r_s1_addr  <= '0;
      r_s1_sew   <= '0;
      r_s1_opsel <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_start <= (r_beat == '0);
      r_s1_end   <= w_last;
      r_s1_avg   <= r_avg;
      r_s1_be    <= w_be;
      r_s1_idx   <= w_elem_off[5:0];
      r_s1_addr  <= w_dst;
      r_s1_sew   <= r_sew;
      r_s1_opsel <= r_opsel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !r_s1_valid) begin
      r_out_valid <= 1'b0;
      r_out_vec0  <= '0;
      r_out_vec1  <= '0;
      r_out_sew   <= '0;
      r_out_opsel <= '0;
      r_out_addr  <= '0;
      r_out_idx   <= '0;
      r_out_start <= 1'b0;
      r_out_end   <= 1'b0;
      r_out_be    <= '0;
      r_out_avg   <= 1'b0;
      r_out_mask  <= 1'b0;
    end else begin
      r_out_valid <= 1'b1;
      r_out_vec0  <= rf_rd_data0;
      r_out_vec1  <= rf_rd_data1;
      r_out_sew   <= r_s1_sew;
      r_out_opsel <= r_s1_opsel;
      r_out_addr  <= r_s1_addr;
      r_out_idx   <= r_s1_idx;
      r_out_start <= r_s1_start;
      r_out_end   <= r_s1_end;
      r_out_be    <= r_s1_be;
      r_out_avg   <= r_s1_avg;
      r_out_mask  <= r_s1_opsel[OPSEL_WIDTH-1];
    end
  end

  assign out_valid     = r_out_valid;
  assign out_vec0      = r_out_vec0;
  assign out_vec1      = r_out_vec1;
  assign out_sew       = r_out_sew;
  assign out_opSel     = r_out_opsel;
  assign out_addr      = r_out_addr;
  assign out_start_idx = r_out_idx;
  assign out_req_start = r_out_start;
  assign out_req_end   = r_out_end;
  assign out_be        = r_out_be;
  assign out_avg       = r_out_avg;
  assign out_mask      = r_out_mask;

endmodule

// File: tb/tb_valu_req_issuer.sv
// Self-checking bench for valu_req_issuer. A reference model turns each
// accepted instruction into the list of reads and ALU beats it must produce,
// stamped with the cycle each must appear; a negedge monitor compares every
// cycle against that list (including all-zero outputs when nothing is due).
module tb_valu_req_issuer;

  localparam int DW  = 64;
  localparam int BEW = 8;
  localparam int AW  = 32;
  localparam int VLW = 11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [AW-1:0]   instr_vs1 = '0, instr_vs2 = '0, instr_vd = '0;
  logic [VLW-1:0]  instr_vl = '0;
  logic [1:0]      instr_sew = '0;
  logic [8:0]      instr_opSel = '0;
  logic            instr_avg = 1'b0;
  logic            rf_rd_en;
  logic [AW-1:0]   rf_rd_addr0, rf_rd_addr1;
  logic [DW-1:0]   rf_rd_data0 = '0, rf_rd_data1 = '0;
  logic            out_valid, out_req_start, out_req_end, out_avg, out_mask;
  logic [DW-1:0]   out_vec0, out_vec1;
  logic [1:0]      out_sew;
  logic [8:0]      out_opSel;
  logic [AW-1:0]   out_addr;
  logic [5:0]      out_start_idx;
  logic [BEW-1:0]  out_be;

  valu_req_issuer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .instr_vl(instr_vl), .instr_sew(instr_sew), .instr_opSel(instr_opSel),
    .instr_avg(instr_avg),
    .rf_rd_en(rf_rd_en), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .out_valid(out_valid), .out_vec0(out_vec0), .out_vec1(out_vec1),
    .out_sew(out_sew), .out_opSel(out_opSel), .out_addr(out_addr),
    .out_start_idx(out_start_idx), .out_req_start(out_req_start),
    .out_req_end(out_req_end), .out_be(out_be), .out_avg(out_avg),
    .out_mask(out_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [AW-1:0] a0, a1;
  } rd_t;

  typedef struct {
    int unsigned cyc;
    logic [DW-1:0] v0, v1;
    logic [1:0] sew;
    logic [8:0] op;
    logic [AW-1:0] addr;
    logic [5:0] idx;
    logic st, en, avg, mask;
    logic [BEW-1:0] be;
  } out_t;

  int unsigned cyc = 0;
  int unsigned free_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit in_reset = 1'b1;
  rd_t  rd_q[$];
  out_t out_q[$];
  rd_t  mon_rd;
  out_t mon_out;

  always @(posedge clk) cyc++;

  // Register-file contents: a fixed, address-dependent pattern per port.
  function automatic logic [DW-1:0] rf0(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0F0F, a * 32'h9E37_79B1};
  endfunction
  function automatic logic [DW-1:0] rf1(input logic [AW-1:0] a);
    return {a * 32'h0101_0003, ~a};
  endfunction

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data0 <= rf0(rf_rd_addr0);
      rf_rd_data1 <= rf1(rf_rd_addr1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      check("instr_ready", instr_ready, 64'(cyc >= free_cyc));
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        mon_rd = rd_q.pop_front();
        check("rd_en", rf_rd_en, 1);
        check("rd_addr0", rf_rd_addr0, mon_rd.a0);
        check("rd_addr1", rf_rd_addr1, mon_rd.a1);
      end else begin
        check("rd_en_idle", rf_rd_en, 0);
        check("rd_addr0_idle", rf_rd_addr0, 0);
        check("rd_addr1_idle", rf_rd_addr1, 0);
      end
      if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
        mon_out = out_q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_vec0", out_vec0, mon_out.v0);
        check("out_vec1", out_vec1, mon_out.v1);
        check("out_sew", out_sew, mon_out.sew);
        check("out_opSel", out_opSel, mon_out.op);
        check("out_addr", out_addr, mon_out.addr);
        check("out_start_idx", out_start_idx, mon_out.idx);
        check("out_req_start", out_req_start, mon_out.st);
        check("out_req_end", out_req_end, mon_out.en);
        check("out_be", out_be, mon_out.be);
        check("out_avg", out_avg, mon_out.avg);
        check("out_mask", out_mask, mon_out.mask);
      end else begin
        check("out_valid_idle", out_valid, 0);
        check("out_fields_idle",
              64'(|{out_vec0, out_vec1, out_sew, out_opSel, out_addr, out_start_idx,
                    out_req_start, out_req_end, out_be, out_avg, out_mask}), 0);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    rd_q.delete();
    out_q.delete();
    free_cyc = cyc;
    in_reset = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one instruction `gap` cycles after the earliest legal slot, then
  // record every read and beat it must produce.
  task automatic issue(input logic [AW-1:0] vs1, input logic [AW-1:0] vs2,
                       input logic [AW-1:0] vd, input int vl, input logic [1:0] sew,
                       input logic [8:0] op, input logic avg, input int gap);
    int unsigned target, p;
    int e, n, elem, bytes;
    rd_t r;
    out_t o;
    target = free_cyc + gap;
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b1;
    instr_vs1 = vs1;
    instr_vs2 = vs2;
    instr_vd = vd;
    instr_vl = VLW'(vl);
    instr_sew = sew;
    instr_opSel = op;
    instr_avg = avg;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    // Scramble the fields: the DUT must have latched them.
    instr_vs1 = $urandom;
    instr_vs2 = $urandom;
    instr_vd = $urandom;
    instr_vl = VLW'($urandom);
    instr_sew = 2'($urandom);
    instr_opSel = 9'($urandom);
    instr_avg = 1'($urandom);
    p = cyc;
    e = BEW >> sew;
    n = (vl + e - 1) / e;
    free_cyc = p + n;
    for (int b = 0; b < n; b++) begin
      elem = b * e;
      bytes = (vl - elem) << sew;
      r.cyc = p + b;
      r.a0 = vs1 + AW'(b);
      r.a1 = vs2 + AW'(b);
      rd_q.push_back(r);
      o.cyc = p + 2 + b;
      o.v0 = rf0(r.a0);
      o.v1 = rf1(r.a1);
      o.sew = sew;
      o.op = op;
      o.addr = op[8] ? vd + AW'(elem / DW) : vd + AW'(b);
      o.idx = 6'(elem % 64);
      o.st = (b == 0);
      o.en = (b == n - 1);
      o.be = (bytes >= BEW) ? 8'hFF : 8'((1 << bytes) - 1);
      o.avg = avg;
      o.mask = op[8];
      out_q.push_back(o);
    end
  endtask

  initial begin
    int vl, sel;
    logic [1:0] sew;
    @(posedge clk);
    #1;
    do_reset(2);
    idle(2);

    // Two-beat byte op.
    issue(32'h10, 32'h20, 32'h30, 16, 2'b00, 9'h000, 1'b0, 0);
    // Halfword op with a partial tail beat.
    issue(32'h100, 32'h200, 32'h300, 5, 2'b01, 9'h012, 1'b1, 2);
    // Compare op: ten beats, destination advances per 64 elements.
    issue(32'h400, 32'h500, 32'h600, 80, 2'b00, 9'h105, 1'b0, 1);
    // Zero length: nothing issued, stays ready.
    issue(32'h1, 32'h2, 32'h3, 0, 2'b10, 9'h001, 1'b0, 1);
    idle(4);
    // Back-to-back instructions, including a 64-bit element tail.
    issue(32'h700, 32'h800, 32'h900, 3, 2'b11, 9'h033, 1'b0, 0);
    issue(32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 7, 2'b10, 9'h144, 1'b1, 0);
    issue(32'hA00, 32'hB00, 32'hC00, 1, 2'b00, 9'h0FF, 1'b0, 0);
    idle(4);

    // Reset while beat 2 of a 4-beat op is being read.
    issue(32'h40, 32'h50, 32'h60, 32, 2'b00, 9'h010, 1'b0, 0);
    idle(2);
    do_reset(1);
    idle(6);

    for (int k = 0; k < 60; k++) begin
      sew = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0) vl = 0;
      else if (sel == 1) vl = (BEW >> sew) * $urandom_range(1, 12);
      else if (sel == 2) vl = $urandom_range(120, 300);
      else vl = $urandom_range(1, 70);
      issue($urandom, $urandom, $urandom, vl, sew, 9'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    while (cyc < free_cyc + 4) idle(1);
    check("drain_rd", 64'(rd_q.size()), 0);
    check("drain_out", 64'(out_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
